// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode constants and control bundle types for the pipelined MIPS control unit
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       regDst;
        logic       aluSrc;
        logic [1:0] aluOp;
    } ex_ctrl_t;

    typedef struct packed {
        logic memRead;
        logic memWrite;
        logic branch;
    } mem_ctrl_t;

    typedef struct packed {
        logic regWrite;
        logic memToReg;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational opcode to control bundle decoder with operand-use flags
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_t               o_ctrl,
    output logic                o_uses_rs,
    output logic                o_uses_rt,
    output logic                o_legal
);

    // Decode table; anything not listed becomes an all-zero NOP bundle
    always_comb begin
        o_ctrl    = '0;
        o_uses_rt = 1'b0;
        o_legal   = 1'b1;
        case (i_opcode)
            OPCODE_W'(OP_RTYPE): begin
                o_ctrl.ex.regDst   = 1'b1;
                o_ctrl.ex.aluOp    = ALUOP_FUNCT;
                o_ctrl.wb.regWrite = 1'b1;
                o_uses_rt          = 1'b1;
            end
            OPCODE_W'(OP_LW): begin
                o_ctrl.ex.aluSrc   = 1'b1;
                o_ctrl.ex.aluOp    = ALUOP_ADD;
                o_ctrl.mem.memRead = 1'b1;
                o_ctrl.wb.regWrite = 1'b1;
                o_ctrl.wb.memToReg = 1'b1;
            end
            OPCODE_W'(OP_SW): begin
                o_ctrl.ex.aluSrc    = 1'b1;
                o_ctrl.ex.aluOp     = ALUOP_ADD;
                o_ctrl.mem.memWrite = 1'b1;
                o_uses_rt           = 1'b1;
            end
            OPCODE_W'(OP_BEQ): begin
                o_ctrl.ex.aluOp   = ALUOP_SUB;
                o_ctrl.mem.branch = 1'b1;
                o_uses_rt         = 1'b1;
            end
            OPCODE_W'(OP_ADDI): begin
                o_ctrl.ex.aluSrc   = 1'b1;
                o_ctrl.ex.aluOp    = ALUOP_ADD;
                o_ctrl.wb.regWrite = 1'b1;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
        // Every real instruction reads rs; NOPs read nothing
        o_uses_rs = o_legal;
    end

endmodule

// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - pipelined control unit with load-use stall and branch flush; optional PIPE_CTRL_ILLEGAL_OP_EN
module pipe_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 6,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [OPCODE_W-1:0]   opCode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  branch_taken,
    output logic                  stallSignal,
    output logic                  ex_regDst,
    output logic                  ex_aluSrc,
    output logic [ALUOP_W-1:0]    ex_aluOp,
    output logic                  mem_memRead,
    output logic                  mem_memWrite,
    output logic                  mem_branch,
    output logic                  wb_regWrite,
    output logic                  wb_memToReg
`ifdef PIPE_CTRL_ILLEGAL_OP_EN
    ,
    output logic                  illegal_op,
    output logic [7:0]            illegal_cnt
`endif
);

    ctrl_t                 w_dec;
    logic                  w_uses_rs;
    logic                  w_uses_rt;
    logic                  w_legal;
    logic                  w_stall;
    logic                  w_bubble;

    ex_ctrl_t              r_idex_ex;
    mem_ctrl_t             r_idex_mem;
    wb_ctrl_t              r_idex_wb;
    logic [REG_ADDR_W-1:0] r_ex_rt;
    mem_ctrl_t             r_exmem_mem;
    wb_ctrl_t              r_exmem_wb;
    wb_ctrl_t              r_memwb_wb;

    ctrl_decoder #(
        .OPCODE_W (OPCODE_W)
    ) u_decoder (
        .i_opcode  (opCode),
        .o_ctrl    (w_dec),
        .o_uses_rs (w_uses_rs),
        .o_uses_rt (w_uses_rt),
        .o_legal   (w_legal)
    );

    // Load-use hazard: the load in EX writes a register the ID instruction reads; $0 never hazards
    always_comb begin
        w_stall = id_valid && r_idex_mem.memRead && (r_ex_rt != '0) &&
                  ((w_uses_rs && (r_ex_rt == id_rs)) || (w_uses_rt && (r_ex_rt == id_rt)));
    end

    assign w_bubble    = branch_taken || w_stall || !id_valid;
    assign stallSignal = w_stall;

    // ID/EX register: bubble on flush, stall or empty slot; ex_rt only follows real instructions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idex_ex  <= '0;
            r_idex_mem <= '0;
            r_idex_wb  <= '0;
            r_ex_rt    <= '0;
        end else if (w_bubble) begin
            r_idex_ex  <= '0;
            r_idex_mem <= '0;
            r_idex_wb  <= '0;
        end else begin
            r_idex_ex  <= w_dec.ex;
            r_idex_mem <= w_dec.mem;
            r_idex_wb  <= w_dec.wb;
            r_ex_rt    <= id_rt;
        end
    end

    // EX/MEM register: a taken branch in MEM kills the instruction behind it in EX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exmem_mem <= '0;
            r_exmem_wb  <= '0;
        end else if (branch_taken) begin
            r_exmem_mem <= '0;
            r_exmem_wb  <= '0;
        end else begin
            r_exmem_mem <= r_idex_mem;
            r_exmem_wb  <= r_idex_wb;
        end
    end

    // MEM/WB register: never flushed, the branch itself is what leaves MEM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memwb_wb <= '0;
        end else begin
            r_memwb_wb <= r_exmem_wb;
        end
    end

    assign ex_regDst    = r_idex_ex.regDst;
    assign ex_aluSrc    = r_idex_ex.aluSrc;
    assign ex_aluOp     = ALUOP_W'(r_idex_ex.aluOp);
    assign mem_memRead  = r_exmem_mem.memRead;
    assign mem_memWrite = r_exmem_mem.memWrite;
    assign mem_branch   = r_exmem_mem.branch;
    assign wb_regWrite  = r_memwb_wb.regWrite;
    assign wb_memToReg  = r_memwb_wb.memToReg;

`ifdef PIPE_CTRL_ILLEGAL_OP_EN
    logic       r_illegal_op;
    logic [7:0] r_illegal_cnt;
    logic       w_illegal_evt;

    assign w_illegal_evt = id_valid && !branch_taken && !w_stall && !w_legal;

    // Sticky flag and saturating count of unsupported opcodes that actually issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal_op  <= 1'b0;
            r_illegal_cnt <= 8'd0;
        end else if (w_illegal_evt) begin
            r_illegal_op <= 1'b1;
            if (r_illegal_cnt != 8'hFF) begin
                r_illegal_cnt <= r_illegal_cnt + 8'd1;
            end
        end
    end

    assign illegal_op  = r_illegal_op;
    assign illegal_cnt = r_illegal_cnt;
`else
    // Unsupported opcodes decode silently as NOPs; the legality flag has no consumer
    logic w_unused_legal;
    assign w_unused_legal = w_legal;
`endif

endmodule
